pid_gain_loader: RTL

Host-side sequencer that drives the 8-bit `setpoint` bus and `rst_n` of the PID controller. It owns the controller's gain-fetch protocol: it pulses the controller into reset, then presents the encoded Kp/Ki/Kd codes in consecutive cycles. After that it switches the bus over to live setpoint traffic. It sits between the host/config register interface and the controller, and allows gains to be reloaded at runtime without a global reset.

---
 rtl/pid_pkg.sv | 33 +++
 rtl/pid_gain_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pid_pkg.sv
// Shared definitions for the PID controller and its host-side gain loader.
// The gain-code constants here must match the controller's decode table.
package pid_pkg;

    localparam int GAIN_CODE_W = 4;
    localparam int DATA_W      = 8;

    localparam logic [GAIN_CODE_W-1:0] GAIN_CODE_ZERO = 4'd0;
    localparam logic [GAIN_CODE_W-1:0] GAIN_CODE_DEF  = 4'd10;
    localparam logic [GAIN_CODE_W-1:0] GAIN_CODE_MAX  = 4'd15;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PULSE   = 3'd1;
    localparam logic [2:0] ST_SEND_KP = 3'd2;
    localparam logic [2:0] ST_SEND_KI = 3'd3;
    localparam logic [2:0] ST_SEND_KD = 3'd4;
    localparam logic [2:0] ST_RUN     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_PULSE   = ST_PULSE,
        S_SEND_KP = ST_SEND_KP,
        S_SEND_KI = ST_SEND_KI,
        S_SEND_KD = ST_SEND_KD,
        S_RUN     = ST_RUN
    } pid_state_e;

    // A gain code travels on the low nibble of the setpoint bus.
    function automatic logic [DATA_W-1:0] gain_to_bus(input logic [GAIN_CODE_W-1:0] code);
        return {{(DATA_W-GAIN_CODE_W){1'b0}}, code};
    endfunction

endpackage

// File: rtl/pid_gain_loader.sv
// Host-side sequencer: pulses the PID controller into reset, streams Kp/Ki/Kd
// over its setpoint bus, then hands the bus over to live setpoint traffic.
module pid_gain_loader
    import pid_pkg::*;
#(
    parameter int unsigned             RST_CYCLES = 2,
    parameter bit                      SKIP_KI    = 1'b0,
    parameter bit                      AUTO_START = 1'b0,
    parameter logic [GAIN_CODE_W-1:0]  DEF_KP     = GAIN_CODE_DEF,
    parameter logic [GAIN_CODE_W-1:0]  DEF_KI     = GAIN_CODE_DEF,
    parameter logic [GAIN_CODE_W-1:0]  DEF_KD     = GAIN_CODE_DEF,
    parameter logic [DATA_W-1:0]       DEF_SP     = 8'd0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [GAIN_CODE_W-1:0] kp_code,
    input  logic [GAIN_CODE_W-1:0] ki_code,
    input  logic [GAIN_CODE_W-1:0] kd_code,
    input  logic                   sp_valid,
    input  logic [DATA_W-1:0]      sp_in,
    output logic                   pid_rst_n,
    output logic [DATA_W-1:0]      setpoint_out,
    output logic                   busy,
    output logic                   running,
    output logic                   load_done
);

    localparam logic [3:0] RST_LOAD = 4'(RST_CYCLES);

    pid_state_e             state_reg, state_next;
    logic [3:0]             cnt_reg, cnt_next;
    logic [GAIN_CODE_W-1:0] kp_reg, kp_next;
    logic [GAIN_CODE_W-1:0] ki_reg, ki_next;
    logic [GAIN_CODE_W-1:0] kd_reg, kd_next;
    logic [DATA_W-1:0]      sp_reg, sp_next;
    logic                   auto_pend_reg;

    logic                   pid_rst_n_reg, pid_rst_n_next;
    logic [DATA_W-1:0]      setpoint_reg, setpoint_next;
    logic                   cfg_ready_reg, cfg_ready_next;
    logic                   busy_reg, busy_next;
    logic                   running_reg, running_next;
    logic                   load_done_reg, load_done_next;

    logic                   accept;

    assign accept = cfg_valid & cfg_ready_reg;

    // Next-state and datapath capture.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        kp_next    = kp_reg;
        ki_next    = ki_reg;
        kd_next    = kd_reg;
        sp_next    = sp_valid ? sp_in : sp_reg;

        case (state_reg)
            S_IDLE, S_RUN: begin
                if (auto_pend_reg) begin
                    state_next = S_PULSE;
                    cnt_next   = RST_LOAD;
                end else if (accept) begin
                    kp_next    = kp_code;
                    ki_next    = ki_code;
                    kd_next    = kd_code;
                    state_next = S_PULSE;
                    cnt_next   = RST_LOAD;
                end
            end
            S_PULSE: begin
                if (cnt_reg <= 4'd1) begin
                    state_next = S_SEND_KP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_SEND_KP: state_next = SKIP_KI ? S_SEND_KD : S_SEND_KI;
            S_SEND_KI: state_next = S_SEND_KD;
            S_SEND_KD: state_next = S_RUN;
            default:   state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        pid_rst_n_next = 1'b0;
        setpoint_next  = '0;
        cfg_ready_next = 1'b0;
        busy_next      = 1'b0;
        running_next   = 1'b0;
        load_done_next = 1'b0;

        case (state_next)
            S_IDLE: cfg_ready_next = 1'b1;
            S_PULSE: busy_next = 1'b1;
            S_SEND_KP: begin
                pid_rst_n_next = 1'b1;
                busy_next      = 1'b1;
                setpoint_next  = gain_to_bus(kp_next);
            end
            S_SEND_KI: begin
                pid_rst_n_next = 1'b1;
                busy_next      = 1'b1;
                setpoint_next  = gain_to_bus(ki_next);
            end
            S_SEND_KD: begin
                pid_rst_n_next = 1'b1;
                busy_next      = 1'b1;
                setpoint_next  = gain_to_bus(kd_next);
            end
            S_RUN: begin
                pid_rst_n_next = 1'b1;
                cfg_ready_next = 1'b1;
                running_next   = 1'b1;
                setpoint_next  = sp_next;
                load_done_next = (state_reg != S_RUN);
            end
            default: cfg_ready_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            kp_reg        <= DEF_KP;
            ki_reg        <= DEF_KI;
            kd_reg        <= DEF_KD;
            sp_reg        <= DEF_SP;
            auto_pend_reg <= AUTO_START;
            pid_rst_n_reg <= 1'b0;
            setpoint_reg  <= '0;
            cfg_ready_reg <= !AUTO_START;
            busy_reg      <= 1'b0;
            running_reg   <= 1'b0;
            load_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            kp_reg        <= kp_next;
            ki_reg        <= ki_next;
            kd_reg        <= kd_next;
            sp_reg        <= sp_next;
            auto_pend_reg <= 1'b0;
            pid_rst_n_reg <= pid_rst_n_next;
            setpoint_reg  <= setpoint_next;
            cfg_ready_reg <= cfg_ready_next;
            busy_reg      <= busy_next;
            running_reg   <= running_next;
            load_done_reg <= load_done_next;
        end
    end

    assign pid_rst_n    = pid_rst_n_reg;
    assign setpoint_out = setpoint_reg;
    assign cfg_ready    = cfg_ready_reg;
    assign busy         = busy_reg;
    assign running      = running_reg;
    assign load_done    = load_done_reg;

endmodule
